// File: rtl/decode_stage_pkg.sv
// Shared types for the RV32I decode stage: opcodes, ALU ops, immediate/memory selectors, ID/EX control word.
// DECODE_STAGE_M_EXT_EN adds the MUL/DIV ALU operations.
package decode_stage_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] xlen_t;
  typedef logic [4:0]      reg_addr_t;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  // ALU_ADD must stay at 0 so a cleared control word means "add".
  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
    ALU_OR, ALU_AND, ALU_PASS_B,
    ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU
`ifdef DECODE_STAGE_M_EXT_EN
    , ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
`endif
  } alu_op_t;

  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_sel_t;

  typedef enum logic [2:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101
  } mem_size_t;

  typedef struct packed {
    alu_op_t   alu_op;
    logic      src_a_pc;
    logic      src_b_imm;
    logic      mem_read;
    logic      mem_write;
    mem_size_t mem_size;
    logic      reg_write;
    logic      branch;
    logic      jump;
    logic      illegal;
  } id_ctrl_t;

endpackage

// File: rtl/decode_stage_decoder.sv
// Combinational RV32I decoder: instruction word -> control word, immediate, rd and source-use flags.
// DECODE_STAGE_M_EXT_EN enables decoding of the M-extension OP encodings.
module instr_decoder
  import decode_stage_pkg::*;
(
  input  logic [31:0] instr,
  output id_ctrl_t    ctrl,
  output xlen_t       imm,
  output reg_addr_t   rd,
  output logic        uses_rs1,
  output logic        uses_rs2
);

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;
  imm_sel_t   imm_sel;
  logic       legal;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  always_comb begin
    ctrl     = '0;
    imm_sel  = IMM_NONE;
    legal    = 1'b1;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    rd       = instr[11:7];
    case (opcode)
      OPC_LUI: begin
        imm_sel = IMM_U;
        ctrl.alu_op = ALU_PASS_B;
        ctrl.src_b_imm = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        imm_sel = IMM_U;
        ctrl.src_a_pc = 1'b1;
        ctrl.src_b_imm = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OPC_JAL: begin
        imm_sel = IMM_J;
        ctrl.src_a_pc = 1'b1;
        ctrl.src_b_imm = 1'b1;
        ctrl.jump = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OPC_JALR: begin
        imm_sel = IMM_I;
        uses_rs1 = 1'b1;
        ctrl.src_b_imm = 1'b1;
        ctrl.jump = 1'b1;
        ctrl.reg_write = 1'b1;
        legal = (funct3 == 3'b000);
      end
      OPC_BRANCH: begin
        imm_sel = IMM_B;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        rd = '0;
        ctrl.branch = 1'b1;
        case (funct3)
          3'b000:  ctrl.alu_op = ALU_BEQ;
          3'b001:  ctrl.alu_op = ALU_BNE;
          3'b100:  ctrl.alu_op = ALU_BLT;
          3'b101:  ctrl.alu_op = ALU_BGE;
          3'b110:  ctrl.alu_op = ALU_BLTU;
          3'b111:  ctrl.alu_op = ALU_BGEU;
          default: legal = 1'b0;
        endcase
      end
      OPC_LOAD: begin
        imm_sel = IMM_I;
        uses_rs1 = 1'b1;
        ctrl.src_b_imm = 1'b1;
        ctrl.mem_read = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.mem_size = mem_size_t'(funct3);
        legal = (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      end
      OPC_STORE: begin
        imm_sel = IMM_S;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        rd = '0;
        ctrl.src_b_imm = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.mem_size = mem_size_t'(funct3);
        legal = (funct3 inside {3'b000, 3'b001, 3'b010});
      end
      OPC_OP_IMM: begin
        imm_sel = IMM_I;
        uses_rs1 = 1'b1;
        ctrl.src_b_imm = 1'b1;
        ctrl.reg_write = 1'b1;
        case (funct3)
          3'b000: ctrl.alu_op = ALU_ADD;
          3'b010: ctrl.alu_op = ALU_SLT;
          3'b011: ctrl.alu_op = ALU_SLTU;
          3'b100: ctrl.alu_op = ALU_XOR;
          3'b110: ctrl.alu_op = ALU_OR;
          3'b111: ctrl.alu_op = ALU_AND;
          3'b001: begin
            ctrl.alu_op = ALU_SLL;
            legal = (funct7 == 7'h00);
          end
          default: begin
            ctrl.alu_op = (funct7 == 7'h20) ? ALU_SRA : ALU_SRL;
            legal = (funct7 == 7'h00) || (funct7 == 7'h20);
          end
        endcase
      end
      OPC_OP: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        ctrl.reg_write = 1'b1;
        if (funct7 == 7'h00) begin
          case (funct3)
            3'b000:  ctrl.alu_op = ALU_ADD;
            3'b001:  ctrl.alu_op = ALU_SLL;
            3'b010:  ctrl.alu_op = ALU_SLT;
            3'b011:  ctrl.alu_op = ALU_SLTU;
            3'b100:  ctrl.alu_op = ALU_XOR;
            3'b101:  ctrl.alu_op = ALU_SRL;
            3'b110:  ctrl.alu_op = ALU_OR;
            default: ctrl.alu_op = ALU_AND;
          endcase
        end else if (funct7 == 7'h20 && funct3 == 3'b000) begin
          ctrl.alu_op = ALU_SUB;
        end else if (funct7 == 7'h20 && funct3 == 3'b101) begin
          ctrl.alu_op = ALU_SRA;
`ifdef DECODE_STAGE_M_EXT_EN
        end else if (funct7 == 7'h01) begin
          case (funct3)
            3'b000:  ctrl.alu_op = ALU_MUL;
            3'b001:  ctrl.alu_op = ALU_MULH;
            3'b010:  ctrl.alu_op = ALU_MULHSU;
            3'b011:  ctrl.alu_op = ALU_MULHU;
            3'b100:  ctrl.alu_op = ALU_DIV;
            3'b101:  ctrl.alu_op = ALU_DIVU;
            3'b110:  ctrl.alu_op = ALU_REM;
            default: ctrl.alu_op = ALU_REMU;
          endcase
`endif
        end else begin
          legal = 1'b0;
        end
      end
      OPC_MISC_MEM: legal = 1'b1;  // FENCE: nothing to order in an in-order core
      OPC_SYSTEM:   legal = 1'b0;  // no CSR/trap support behind this stage
      default:      legal = 1'b0;
    endcase
    if (!legal) begin
      ctrl.reg_write = 1'b0;
      ctrl.mem_read  = 1'b0;
      ctrl.mem_write = 1'b0;
      ctrl.branch    = 1'b0;
      ctrl.jump      = 1'b0;
      ctrl.illegal   = 1'b1;
    end
  end

  always_comb begin
    case (imm_sel)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'b0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage with ID/EX register, one-bubble load-use interlock and EX flush.
// DECODE_STAGE_M_EXT_EN enables MUL/DIV decode in the instruction decoder.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter xlen_t RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid_i,
  output logic            if_ready_o,
  input  logic [31:0]     if_instr_i,
  input  logic [XLEN-1:0] if_pc_i,
  output logic [4:0]      rs1_addr_o,
  output logic [4:0]      rs2_addr_o,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic            flush_i,
  input  logic            ex_ready_i,
  output logic            ex_valid_o,
  output logic [XLEN-1:0] ex_pc_o,
  output logic [XLEN-1:0] ex_rs1_data_o,
  output logic [XLEN-1:0] ex_rs2_data_o,
  output logic [XLEN-1:0] ex_imm_o,
  output logic [4:0]      ex_rs1_addr_o,
  output logic [4:0]      ex_rs2_addr_o,
  output logic [4:0]      ex_rd_addr_o,
  output id_ctrl_t        ex_ctrl_o
);

  id_ctrl_t  dec_ctrl;
  xlen_t     dec_imm;
  reg_addr_t dec_rd;
  logic      uses_rs1;
  logic      uses_rs2;
  logic      advance;
  logic      hazard;

  instr_decoder u_dec (
    .instr    (if_instr_i),
    .ctrl     (dec_ctrl),
    .imm      (dec_imm),
    .rd       (dec_rd),
    .uses_rs1 (uses_rs1),
    .uses_rs2 (uses_rs2)
  );

  assign rs1_addr_o = if_instr_i[19:15];
  assign rs2_addr_o = if_instr_i[24:20];

  assign advance = !ex_valid_o || ex_ready_i;

  // Load in ID/EX whose result a source of the incoming instruction needs.
  assign hazard = if_valid_i && ex_valid_o && ex_ctrl_o.mem_read && (ex_rd_addr_o != 5'd0) &&
                  ((uses_rs1 && rs1_addr_o == ex_rd_addr_o) ||
                   (uses_rs2 && rs2_addr_o == ex_rd_addr_o));

  assign if_ready_o = !rst && (flush_i || (advance && !hazard));

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_o    <= 1'b0;
      ex_pc_o       <= RESET_PC;
      ex_rs1_data_o <= '0;
      ex_rs2_data_o <= '0;
      ex_imm_o      <= '0;
      ex_rs1_addr_o <= '0;
      ex_rs2_addr_o <= '0;
      ex_rd_addr_o  <= '0;
      ex_ctrl_o     <= '0;
    end else if (flush_i) begin
      ex_valid_o <= 1'b0;
    end else if (advance) begin
      if (hazard || !if_valid_i) begin
        ex_valid_o <= 1'b0;
      end else begin
        ex_valid_o    <= 1'b1;
        ex_pc_o       <= if_pc_i;
        ex_rs1_data_o <= rs1_data_i;
        ex_rs2_data_o <= rs2_data_i;
        ex_imm_o      <= dec_imm;
        ex_rs1_addr_o <= rs1_addr_o;
        ex_rs2_addr_o <= rs2_addr_o;
        ex_rd_addr_o  <= dec_rd;
        ex_ctrl_o     <= dec_ctrl;
      end
    end
  end

endmodule
